// File: rtl/chaser_fader.sv
// Light-chaser trail fader: each LED channel snaps to full brightness when lit
// and then fades linearly, rendered as PWM against a shared free-running counter.
module chaser_fader #(
    parameter int PWM_BITS    = 4,
    parameter int DECAY_TICKS = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [4:0] l_in,
    output logic [4:0] pwm_out,
    output logic       onehot_err
);

    localparam logic [PWM_BITS-1:0] MAX      = '1;
    localparam logic [7:0]          PRE_LAST = 8'(DECAY_TICKS - 1);

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [7:0]          pre;
    logic                decay_tick;
    logic [PWM_BITS-1:0] bright [5];

    assign decay_tick = (pre == PRE_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt    <= '0;
            pre        <= '0;
            pwm_out    <= '0;
            onehot_err <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                bright[i] <= '0;
            end
        end else begin
            pwm_cnt    <= pwm_cnt + 1'b1;
            pre        <= decay_tick ? 8'd0 : pre + 8'd1;
            onehot_err <= ($countones(l_in) != 1);
            for (int i = 0; i < 5; i++) begin
                pwm_out[i] <= (pwm_cnt < bright[i]);
                // a lit LED wins over a coincident decay step
                if (l_in[i]) begin
                    bright[i] <= MAX;
                end else if (decay_tick && bright[i] != '0) begin
                    bright[i] <= bright[i] - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_chaser_fader.sv
// Randomized bench for chaser_fader against an arithmetic fade model.
module tb_chaser_fader;

    localparam int PB  = 4;
    localparam int DT  = 8;
    localparam int MX  = (1 << PB) - 1;
    localparam int PER = 1 << PB;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] l_in;
    logic [4:0] pwm_out;
    logic       onehot_err;

    int checks = 0;
    int errors = 0;

    int         n;
    int         br [5];
    logic [4:0] exp_pwm;
    logic       exp_err;

    chaser_fader #(.PWM_BITS(PB), .DECAY_TICKS(DT)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .l_in      (l_in),
        .pwm_out   (pwm_out),
        .onehot_err(onehot_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at n=%0d t=%0t",
                     tag, got, exp, n, $time);
        end
    endtask

    task automatic model_reset();
        n = 0;
        for (int i = 0; i < 5; i++) br[i] = 0;
    endtask

    // Drive one pattern for one edge; model computes outputs from pre-edge state.
    task automatic cycle(input logic [4:0] pat);
        bit tick;
        l_in = pat;
        for (int i = 0; i < 5; i++) exp_pwm[i] = ((n % PER) < br[i]);
        exp_err = ($countones(pat) != 1);
        tick = ((n % DT) == DT - 1);
        for (int i = 0; i < 5; i++) begin
            if (pat[i]) br[i] = MX;
            else if (tick && br[i] > 0) br[i] = br[i] - 1;
        end
        n++;
        @(posedge clk);
        #1;
        check("pwm_out", 32'(pwm_out), 32'(exp_pwm));
        check("onehot_err", 32'(onehot_err), 32'(exp_err));
    endtask

    task automatic do_reset(input int hold);
        l_in = 5'($urandom);
        reset_n = 1'b0;
        #1;
        check("rst_pwm", 32'(pwm_out), 32'd0);
        check("rst_err", 32'(onehot_err), 32'd0);
        model_reset();
        repeat (hold) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    function automatic logic [4:0] rand_pat();
        int k;
        k = $urandom_range(0, 9);
        if (k < 6) return 5'(1 << $urandom_range(0, 4));
        if (k == 6) return 5'b00000;
        return 5'($urandom);
    endfunction

    initial begin
        reset_n = 1'b0;
        l_in    = 5'b10101;
        model_reset();
        #2;
        check("init_pwm", 32'(pwm_out), 32'd0);
        check("init_err", 32'(onehot_err), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // full duty on channel 0, then a full fade while channel 1 is lit
        repeat (40) cycle(5'b00001);
        repeat (130) cycle(5'b00010);

        // one-hot flag cases
        cycle(5'b00000);
        cycle(5'b00011);
        cycle(5'b00100);

        // land a channel-2 load exactly on a decay tick
        repeat (20) cycle(5'b00000);
        while ((n % DT) != DT - 1) cycle(5'b00000);
        cycle(5'b00100);
        repeat (40) cycle(5'b00000);

        // reset mid-fade: no residual glow on channel 0
        repeat (20) cycle(5'b00001);
        repeat (6 * DT) cycle(5'b00010);
        do_reset(1);
        repeat (40) cycle(5'b00010);

        // randomized runs with occasional reset pulses
        for (int r = 0; r < 300; r++) begin
            logic [4:0] p;
            p = rand_pat();
            repeat ($urandom_range(1, 24)) cycle(p);
            if ($urandom_range(0, 29) == 0) do_reset($urandom_range(1, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/chaser_fader.md
CHASER_FADER -- requirements
Module: chaser_fader

Interface
REQ-001 SHALL have parameter PWM_BITS, default 4, giving the PWM counter width; PWM period = 2^PWM_BITS cycles.
REQ-002 SHALL have parameter DECAY_TICKS, default 8, giving the clock cycles between brightness decrement steps (legal range 1 to 255).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port l_in  input  5  LED pattern from the upstream light-chaser stage; nominally one-hot.
REQ-006 SHALL have port pwm_out  output  5  registered PWM drive, one bit per LED.
REQ-007 SHALL have port onehot_err  output  1  registered flag: previous-cycle l_in was not exactly one-hot.

Function
REQ-008 SHALL keep a free-running pwm_cnt of PWM_BITS bits, incrementing every cycle and wrapping from 2^PWM_BITS-1 to 0.
REQ-009 SHALL keep a prescaler counting 0 to DECAY_TICKS-1 and wrapping; decay_tick SHALL be asserted in the cycle the prescaler equals DECAY_TICKS-1.
REQ-010 SHALL keep one PWM_BITS-wide brightness register per channel i, 0 to 4.
REQ-011 SHALL, on each edge where l_in[i]=1, load brightness[i] to MAX = 2^PWM_BITS-1 (15 by default).
REQ-012 SHALL, on each edge where l_in[i]=0 and decay_tick=1, decrement brightness[i] by 1, saturating at 0 with no wrap to MAX.
REQ-013 SHALL hold brightness[i] when l_in[i]=0 and decay_tick=0.
REQ-014 SHALL give load priority over decay when l_in[i]=1 coincides with decay_tick.
REQ-015 SHALL register pwm_out[i] <= (pwm_cnt < brightness[i]), using the pre-edge values of both.
REQ-016 SHALL therefore give a duty cycle of brightness/2^PWM_BITS: brightness 0 gives a constant 0; MAX gives high on every cycle except pwm_cnt = MAX.
REQ-017 SHALL have a latency from a change in l_in to a change in pwm_out of 2 edges: the brightness update, then the output register.
REQ-018 SHALL treat each channel independently: multi-hot l_in loads every set channel, and all-zero l_in lets every channel decay.
REQ-019 SHALL register onehot_err <= (popcount(l_in) != 1) every cycle; the flag is not sticky.
REQ-020 SHALL NOT use l_in as a clock or as an asynchronous input; l_in is synchronous to clk.

Reset
REQ-021 SHALL, while reset_n=0, immediately and asynchronously force pwm_out=00000, onehot_err=0, pwm_cnt=0, prescaler=0 and all brightness registers to 0.
REQ-022 SHALL, on the first edge after reset_n rises, resume normal operation from the zero state, with pwm_cnt=0 counting up.
REQ-023 SHALL, when reset is asserted mid-fade, discard all fade state; no residual glow after release unless l_in reloads a channel.

Verification (PWM_BITS=4, DECAY_TICKS=8)
REQ-024 SHALL cover: reset_n=0 with arbitrary l_in -> pwm_out=00000 and onehot_err=0 at once, without waiting for a clock edge.
REQ-025 SHALL cover: l_in=00001 held from reset release -> from edge 2, pwm_out[0]=1 on 15 of every 16 cycles (0 only after pwm_cnt=15) and pwm_out[4:1]=0.
REQ-026 SHALL cover: l_in 00001 -> 00010 -> brightness[0] steps 15, 14, ..., 0, one step per 8 cycles, reaching 0 within 120 cycles; pwm_out[0] duty falls monotonically and then stays 0; channel 1 is at full duty.
REQ-027 SHALL cover: l_in=00000 and l_in=00011 -> onehot_err=1 one edge later; l_in=00100 -> onehot_err=0 one edge later.
REQ-028 SHALL cover: l_in[2] rising in the same cycle as decay_tick -> brightness[2]=15, not 14.
REQ-029 SHALL cover: reset_n pulsed low for 1 cycle while brightness[0]=9 -> all brightness 0; after release with l_in=00010, pwm_out[0] stays 0.
